// File: rtl/param_updown_counter_if.sv
// Control and status bundle for one param_updown_counter stage.
// master drives the controls and observes the count; slave is the counter itself.
interface param_updown_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             cin;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clear;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             cout;
   logic             wrap;

   modport master (
      output en, cin, up_dn, load, load_val, clear,
      input  q, tc, cout, wrap
   );

   modport slave (
      input  en, cin, up_dn, load, load_val, clear,
      output q, tc, cout, wrap
   );
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with load, clear, saturate/wrap mode and
// combinational carry so stages chain into one synchronous counter.
module param_updown_counter #(
   parameter int unsigned     WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int unsigned     SATURATE = 0
) (
   input logic                   clk,
   input logic                   reset,
   param_updown_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_r;
   logic             wrap_nxt;
   logic             at_limit;
   logic             step;

   // The limit depends on direction, so tc flips as soon as up_dn changes.
   always_comb begin
      at_limit = bus.up_dn ? (q_r == MAXV) : (q_r == '0);
      step     = bus.en & bus.cin;
   end

   always_comb begin
      q_nxt    = q_r;
      wrap_nxt = 1'b0;
      if (bus.clear) begin
         q_nxt = '0;
      end else if (bus.load) begin
         q_nxt = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      end else if (step) begin
         if (at_limit) begin
            wrap_nxt = 1'b1;
            if (SATURATE == 0) begin
               q_nxt = bus.up_dn ? '0 : MAXV;
            end
         end else begin
            q_nxt = bus.up_dn ? (q_r + WIDTH'(1)) : (q_r - WIDTH'(1));
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r    <= '0;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
      end
   end

   assign bus.q    = q_r;
   assign bus.wrap = wrap_r;
   assign bus.tc   = at_limit;
   assign bus.cout = at_limit & step;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed checks of wrap mode, saturate mode and a two-stage decade cascade.
module tb_param_updown_counter;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   e;

   always #5 clk = ~clk;

   param_updown_counter_if #(.WIDTH(4)) w_if ();
   param_updown_counter_if #(.WIDTH(4)) s_if ();
   param_updown_counter_if #(.WIDTH(4)) lo_if ();
   param_updown_counter_if #(.WIDTH(4)) hi_if ();

   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .bus(w_if.slave));
   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .bus(s_if.slave));
   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
      .clk(clk), .reset(reset), .bus(lo_if.slave));
   param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
      .clk(clk), .reset(reset), .bus(hi_if.slave));

   assign hi_if.cin = lo_if.cout;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      #2;
      chk("rst_pulse_q", 32'(w_if.q), 0);
      chk("rst_pulse_wrap", 32'(w_if.wrap), 0);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      w_if.en = 1'b0;  w_if.cin = 1'b1;  w_if.up_dn = 1'b0;
      w_if.load = 1'b1; w_if.load_val = 4'd5; w_if.clear = 1'b0;
      s_if.en = 1'b0;  s_if.cin = 1'b1;  s_if.up_dn = 1'b1;
      s_if.load = 1'b0; s_if.load_val = '0; s_if.clear = 1'b0;
      lo_if.en = 1'b0; lo_if.cin = 1'b1; lo_if.up_dn = 1'b1;
      lo_if.load = 1'b0; lo_if.load_val = '0; lo_if.clear = 1'b0;
      hi_if.en = 1'b0; hi_if.up_dn = 1'b1;
      hi_if.load = 1'b0; hi_if.load_val = '0; hi_if.clear = 1'b0;

      // Reset asserted: outputs forced, load ignored across an edge
      #1 reset = 1'b0;
      #1;
      chk("rst_q", 32'(w_if.q), 0);
      chk("rst_wrap", 32'(w_if.wrap), 0);
      chk("rst_tc_down", 32'(w_if.tc), 1);
      chk("rst_cout", 32'(w_if.cout), 0);
      tick();
      chk("rst_ignore_load", 32'(w_if.q), 0);
      reset = 1'b1;
      w_if.load = 1'b0; w_if.en = 1'b1; w_if.up_dn = 1'b1;
      #1;
      chk("tc_up_at0", 32'(w_if.tc), 0);

      // Up count 1..9,0,1,2
      e = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         e = (e + 1) % 10;
         chk("up_q", 32'(w_if.q), 32'(e));
         chk("up_wrap", 32'(w_if.wrap), 32'(e == 0));
         chk("up_tc", 32'(w_if.tc), 32'(e == 9));
         chk("up_cout", 32'(w_if.cout), 32'(e == 9));
      end

      // Clear wins over enabled count, then count down from 0
      w_if.clear = 1'b1; w_if.up_dn = 1'b0;
      tick();
      chk("clr_q", 32'(w_if.q), 0);
      chk("clr_wrap", 32'(w_if.wrap), 0);
      w_if.clear = 1'b0;
      #1;
      chk("dn_tc_at0", 32'(w_if.tc), 1);
      e = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         e = (e + 9) % 10;
         chk("dn_q", 32'(w_if.q), 32'(e));
         chk("dn_wrap", 32'(w_if.wrap), 32'(i == 0));
         chk("dn_tc", 32'(w_if.tc), 0);
      end

      // Direction change takes effect on the very next edge
      w_if.up_dn = 1'b1;
      tick();
      chk("dir_up_q", 32'(w_if.q), 7);
      w_if.up_dn = 1'b0;
      tick();
      chk("dir_dn_q", 32'(w_if.q), 6);

      // Async reset between edges at q=6, then resume from 0
      reset_pulse();
      w_if.up_dn = 1'b1;
      tick();
      chk("resume_q", 32'(w_if.q), 1);

      // Reset clears a pending wrap pulse
      w_if.load = 1'b1; w_if.load_val = 4'd9;
      tick();
      chk("load_over_count", 32'(w_if.q), 9);
      w_if.load = 1'b0;
      tick();
      chk("wrap_before_rst", 32'(w_if.wrap), 1);
      reset_pulse();

      // Reset held across an edge aborts a load; load applies after release
      w_if.en = 1'b0; w_if.load = 1'b1; w_if.load_val = 4'd5;
      reset = 1'b0;
      tick();
      chk("rst_abort_load", 32'(w_if.q), 0);
      reset = 1'b1;
      tick();
      chk("load_after_rel", 32'(w_if.q), 5);

      // Load clamping and priorities
      w_if.load_val = 4'd13;
      tick();
      chk("load13_clamp", 32'(w_if.q), 9);
      chk("load_wrap", 32'(w_if.wrap), 0);
      w_if.load_val = 4'd3;
      tick();
      chk("load3", 32'(w_if.q), 3);
      w_if.load_val = 4'd10;
      tick();
      chk("load10_clamp", 32'(w_if.q), 9);
      w_if.clear = 1'b1;
      tick();
      chk("load_clear", 32'(w_if.q), 0);
      w_if.clear = 1'b0; w_if.load_val = 4'd15; w_if.up_dn = 1'b1;
      tick();
      chk("load15_clamp", 32'(w_if.q), 9);
      w_if.load = 1'b0;
      #1;
      chk("tc_up_at9", 32'(w_if.tc), 1);
      w_if.up_dn = 1'b0;
      #1;
      chk("tc_dn_at9", 32'(w_if.tc), 0);

      // Hold when either enable is low
      w_if.en = 1'b1; w_if.cin = 1'b0; w_if.up_dn = 1'b1;
      #1;
      chk("cout_cin0", 32'(w_if.cout), 0);
      tick();
      chk("hold_cin0_q", 32'(w_if.q), 9);
      chk("hold_cin0_wrap", 32'(w_if.wrap), 0);
      w_if.en = 1'b0; w_if.cin = 1'b1;
      tick();
      chk("hold_en0_q", 32'(w_if.q), 9);

      // Saturating instance
      s_if.load = 1'b1; s_if.load_val = 4'd8;
      tick();
      chk("sat_load8", 32'(s_if.q), 8);
      s_if.load = 1'b0; s_if.en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sat_up_q", 32'(s_if.q), 9);
         chk("sat_up_wrap", 32'(s_if.wrap), 32'(i != 0));
         chk("sat_cout", 32'(s_if.cout), 1);
      end
      s_if.cin = 1'b0;
      tick();
      chk("sat_hold_wrap", 32'(s_if.wrap), 0);
      s_if.cin = 1'b1; s_if.clear = 1'b1;
      tick();
      chk("sat_clear", 32'(s_if.q), 0);
      s_if.clear = 1'b0; s_if.up_dn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("sat_dn_q", 32'(s_if.q), 0);
         chk("sat_dn_wrap", 32'(s_if.wrap), 1);
      end
      s_if.up_dn = 1'b1;
      tick();
      chk("sat_leave_q", 32'(s_if.q), 1);
      chk("sat_leave_wrap", 32'(s_if.wrap), 0);

      // Two-stage decade cascade: 00..99 then 00
      lo_if.clear = 1'b1; hi_if.clear = 1'b1;
      tick();
      lo_if.clear = 1'b0; hi_if.clear = 1'b0;
      lo_if.en = 1'b1; hi_if.en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         chk("casc_val", 32'(hi_if.q) * 10 + 32'(lo_if.q), 32'(k % 100));
         if (k == 10) chk("casc_hi_nowrap", 32'(hi_if.wrap), 0);
         if (k == 100) chk("casc_hi_wrap", 32'(hi_if.wrap), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter MODULUS, default 16, count sequence length; legal range 2..2**WIDTH; count range 0..MODULUS-1.
REQ-003 Parameter SATURATE, default 0, mode: 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
REQ-006 Port en  input  1  count enable; also gated by cin.
REQ-007 Port cin  input  1  cascade enable from the lower stage; tie 1 when unused.
REQ-008 Port up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 Port load  input  1  synchronous load strobe.
REQ-010 Port load_val  input  WIDTH  value applied on load.
REQ-011 Port clear  input  1  synchronous clear to 0.
REQ-012 Port q  output  WIDTH  registered count.
REQ-013 Port tc  output  1  combinational terminal count: q==MODULUS-1 when up_dn=1, q==0 when up_dn=0.
REQ-014 Port cout  output  1  combinational cascade carry: tc & en & cin.
REQ-015 Port wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap or saturation hit.

Function
REQ-016 Per rising clk edge, priority SHALL be clear > load > count > hold.
REQ-017 clear=1: q <- 0, wrap <- 0, regardless of en, cin, load.
REQ-018 load=1 (clear=0): q <- load_val if load_val < MODULUS, else q <- MODULUS-1 (clamp); wrap <- 0.
REQ-019 Count step occurs only when en=1 and cin=1 and neither clear nor load is asserted.
REQ-020 Up step, q < MODULUS-1: q <- q+1, wrap <- 0.
REQ-021 Up step, q == MODULUS-1: SATURATE=0 -> q <- 0; SATURATE=1 -> q holds; wrap <- 1 in both modes.
REQ-022 Down step, q > 0: q <- q-1, wrap <- 0.
REQ-023 Down step, q == 0: SATURATE=0 -> q <- MODULUS-1; SATURATE=1 -> q holds; wrap <- 1 in both modes.
REQ-024 No step (hold): q unchanged, wrap <- 0; wrap SHALL never be high for two cycles unless two consecutive limit steps occur.
REQ-025 Direction change SHALL take effect on the same edge; no extra latency or state.
REQ-026 Arithmetic SHALL be modulo MODULUS, never modulo 2**WIDTH; q SHALL never exceed MODULUS-1.
REQ-027 Cascading: stage N+1 cin = stage N cout; the chain SHALL count as one synchronous counter with no ripple clocking.
REQ-028 tc and cout SHALL reflect q and up_dn combinationally with no register delay.

Reset
REQ-029 reset=0 SHALL force q=0 and wrap=0 immediately, independent of clk.
REQ-030 While reset=0, all inputs SHALL be ignored; tc/cout follow q=0 (tc=1 only if up_dn=0).
REQ-031 The first rising clk edge after reset deassertion SHALL apply normal REQ-016 priority.
REQ-032 Reset asserted mid-count or mid-load SHALL abort the operation; no partial update survives.

Verification
REQ-033 WIDTH=4, MODULUS=10, SATURATE=0, en=cin=up_dn=1 for 12 edges from reset -> q 1..9,0,1,2; wrap high one cycle after q 9->0; tc high while q=9.
REQ-034 Same config, up_dn=0 from q=0 -> q=9, wrap pulse; then 8,7...; tc high while q=0.
REQ-035 SATURATE=1, MODULUS=10, up from load 8 -> q 9,9,9; wrap high each limit step; cout=1 while q=9 & en & cin.
REQ-036 load=1, load_val=13 (MODULUS=10) -> q=9; load and clear together -> q=0; load with en=0 -> load still applied.
REQ-037 reset pulsed low between clock edges at q=6 -> q=0 and wrap=0 before the next edge; counting resumes from 0 after release.
REQ-038 Two instances cascaded (MODULUS=10 each), up for 100 edges -> {hi,lo} steps 00..99 then 00; hi advances only on lo 9->0.
